coin_key_conditioner: RTL and testbench

Input front end of the coffee machine: synchronizes, debounces and edge-detects the raw coin-slot contacts (100 and 500 coins) and the five product keys. It emits clean single-cycle pulses directly into the machine controller's coin inputs `C`, `Q` and key inputs `e`, `l`, `x`, `m`, `a`. It guarantees at most one coin pulse per cycle, so the downstream coin counters never miss a simultaneous insertion.

---
 rtl/coin_key_conditioner.sv | 182 ++++++++++++++++++
 tb/tb_coin_key_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/coin_key_conditioner.sv
// Coin/key front end: 2-flop sync, per-channel debounce FSM, one-coin-per-cycle arbiter.
// Optional feature macro: COIN_REJECT_EN (refuse coins while accept_coin is low).
module coin_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_raw,
    input  logic       q_raw,
    input  logic [4:0] key_raw,
    input  logic       accept_coin,
    output logic       c_pulse,
    output logic       q_pulse,
    output logic [4:0] key_pulse,
    output logic       coin_reject
);

    localparam int         NCH      = 7;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // Channel order: 0 = c, 1 = q, 2..6 = key[0..4]
    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] sync1_r;
    logic [NCH-1:0] sync2_r;
    logic [NCH-1:0] strobe_s;

    assign raw_s = {key_raw, q_raw, c_raw};

    // Two-flop synchronizer for all raw contacts
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 7'd0;
            sync2_r <= 7'd0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        db_state_t  state_r;
        db_state_t  state_nxt_s;
        logic [7:0] cnt_r;
        logic [7:0] cnt_nxt_s;
        logic       strobe_r;
        logic       strobe_nxt_s;

        // Debounce next-state: a level change is accepted only after a stable run
        always_comb begin
            state_nxt_s  = state_r;
            cnt_nxt_s    = cnt_r;
            strobe_nxt_s = 1'b0;
            case (state_r)
                IDLE: begin
                    if (sync2_r[g]) begin
                        state_nxt_s = PRESS_WAIT;
                        cnt_nxt_s   = 8'd1;
                    end else begin
                        cnt_nxt_s   = 8'd0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_r[g]) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = 8'd0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s  = HELD;
                        cnt_nxt_s    = 8'd0;
                        strobe_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end
                end
                HELD: begin
                    if (!sync2_r[g]) begin
                        state_nxt_s = RELEASE_WAIT;
                        cnt_nxt_s   = 8'd1;
                    end else begin
                        cnt_nxt_s   = 8'd0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_r[g]) begin
                        state_nxt_s = HELD;
                        cnt_nxt_s   = 8'd0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 8'd0;
                end
            endcase
        end

        // Debounce state, counter and registered accept strobe
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_r  <= IDLE;
                cnt_r    <= 8'd0;
                strobe_r <= 1'b0;
            end else begin
                state_r  <= state_nxt_s;
                cnt_r    <= cnt_nxt_s;
                strobe_r <= strobe_nxt_s;
            end
        end

        assign strobe_s[g] = strobe_r;
    end

    logic c_pend_r;
    logic q_pend_r;
    logic c_pend_nxt_s;
    logic q_pend_nxt_s;
    logic grant_c_s;
    logic grant_q_s;
    logic accept_ok_s;

`ifdef COIN_REJECT_EN
    assign accept_ok_s = accept_coin;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_coin;
    assign accept_ok_s     = 1'b1;
`endif

    // Coin arbiter: pending coins are older, so they win; the loser is parked
    always_comb begin
        grant_c_s    = 1'b0;
        grant_q_s    = 1'b0;
        c_pend_nxt_s = c_pend_r | strobe_s[0];
        q_pend_nxt_s = q_pend_r | strobe_s[1];
        if (c_pend_r) begin
            grant_c_s    = 1'b1;
            c_pend_nxt_s = strobe_s[0];
        end else if (q_pend_r) begin
            grant_q_s    = 1'b1;
            q_pend_nxt_s = strobe_s[1];
        end else if (strobe_s[0]) begin
            grant_c_s    = 1'b1;
            c_pend_nxt_s = 1'b0;
        end else if (strobe_s[1]) begin
            grant_q_s    = 1'b1;
            q_pend_nxt_s = 1'b0;
        end else begin
            grant_c_s = 1'b0;
            grant_q_s = 1'b0;
        end
    end

    // Pending flags and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_pend_r    <= 1'b0;
            q_pend_r    <= 1'b0;
            c_pulse     <= 1'b0;
            q_pulse     <= 1'b0;
            key_pulse   <= 5'd0;
            coin_reject <= 1'b0;
        end else begin
            c_pend_r    <= c_pend_nxt_s;
            q_pend_r    <= q_pend_nxt_s;
            c_pulse     <= grant_c_s & accept_ok_s;
            q_pulse     <= grant_q_s & accept_ok_s;
            key_pulse   <= strobe_s[6:2];
            coin_reject <= (grant_c_s | grant_q_s) & ~accept_ok_s;
        end
    end

endmodule

// File: tb/tb_coin_key_conditioner.sv
// Bench for coin_key_conditioner: level-acceptance model plus FIFO coin model, checked every cycle.
module tb_coin_key_conditioner;

    localparam int D = 4;
`ifdef COIN_REJECT_EN
    localparam bit REJ_EN = 1'b1;
`else
    localparam bit REJ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       c_raw, q_raw, accept_coin;
    logic [4:0] key_raw;
    logic       c_pulse, q_pulse, coin_reject;
    logic [4:0] key_pulse;

    coin_key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .c_raw(c_raw), .q_raw(q_raw), .key_raw(key_raw),
        .accept_coin(accept_coin), .c_pulse(c_pulse), .q_pulse(q_pulse),
        .key_pulse(key_pulse), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a channel's accepted level flips after D consecutive synced samples at the other value
    logic [6:0] m_d1, m_d2, m_lvl, m_stb;
    int         m_run [7];
    bit         m_q   [$];
    logic       exp_c, exp_q, exp_rej;
    logic [4:0] exp_key;

    always @(posedge clk) begin
        logic [6:0] s;
        logic [6:0] stb;
        bit         k;
        cyc = cyc + 1;
        if (!rst) begin
            m_d1 = 7'd0; m_d2 = 7'd0; m_lvl = 7'd0; m_stb = 7'd0;
            for (int i = 0; i < 7; i++) m_run[i] = 0;
            m_q.delete();
            exp_c = 1'b0; exp_q = 1'b0; exp_rej = 1'b0; exp_key = 5'd0;
        end else begin
            s = m_d2; m_d2 = m_d1; m_d1 = {key_raw, q_raw, c_raw};
            exp_key = m_stb[6:2];
            if (m_stb[0]) m_q.push_back(1'b0);
            if (m_stb[1]) m_q.push_back(1'b1);
            exp_c = 1'b0; exp_q = 1'b0; exp_rej = 1'b0;
            if (m_q.size() > 0) begin
                k = m_q.pop_front();
                if (REJ_EN && !accept_coin) exp_rej = 1'b1;
                else if (!k)                exp_c   = 1'b1;
                else                        exp_q   = 1'b1;
            end
            stb = 7'd0;
            for (int i = 0; i < 7; i++) begin
                if (s[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_lvl[i] = s[i];
                        m_run[i] = 0;
                        stb[i]   = s[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_stb = stb;
        end
    end

    int n_c = 0, n_q = 0, n_rej = 0, n_k0 = 0, n_k2 = 0, n_kother = 0, n_both = 0;
    int last_c = -1, last_q = -1, last_k = -1;
    logic [4:0] last_kval = 5'd0;

    // Per-cycle comparison against the model, plus event bookkeeping
    always @(negedge clk) begin
        if (cyc > 0) begin
            total = total + 1;
            if ({c_pulse, q_pulse, key_pulse, coin_reject} !== {exp_c, exp_q, exp_key, exp_rej}) begin
                bad = bad + 1;
                $display("FAIL outputs cyc=%0d got c,q,key,rej=%b required=%b", cyc,
                         {c_pulse, q_pulse, key_pulse, coin_reject}, {exp_c, exp_q, exp_key, exp_rej});
            end
            if (c_pulse) begin n_c++; last_c = cyc; end
            if (q_pulse) begin n_q++; last_q = cyc; end
            if (c_pulse && q_pulse) n_both++;
            if (coin_reject) n_rej++;
            if (key_pulse[0]) n_k0++;
            if (key_pulse[2]) n_k2++;
            if (key_pulse[1] || key_pulse[3] || key_pulse[4]) n_kother++;
            if (key_pulse != 5'd0) begin last_k = cyc; last_kval = key_pulse; end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int start, b_c, b_q, b_r, b_k0, b_k2, b_ko;

    initial begin
        rst = 1'b0; c_raw = 1'b0; q_raw = 1'b0; key_raw = 5'd0; accept_coin = 1'b1;
        tick(3);
        check("reset_outputs", int'({c_pulse, q_pulse, key_pulse, coin_reject}), 0);
        rst = 1'b1;
        tick(2);

        // Clean coin
        b_c = n_c; start = cyc + 1; c_raw = 1'b1;
        tick(20);
        check("clean_c_count", n_c - b_c, 1);
        check("clean_c_cycle", last_c - start, 6);
        c_raw = 1'b0; tick(12);

        // Bouncing 500 coin
        b_q = n_q;
        q_raw = 1'b1; tick(1); q_raw = 1'b0; tick(1);
        q_raw = 1'b1; tick(1); q_raw = 1'b0; tick(1);
        q_raw = 1'b1; start = cyc + 1;
        tick(10);
        check("bounce_q_count", n_q - b_q, 1);
        check("bounce_q_cycle", last_q - start, 6);
        q_raw = 1'b0; tick(12);

        // Simultaneous coins
        b_c = n_c; b_q = n_q; start = cyc + 1; c_raw = 1'b1; q_raw = 1'b1;
        tick(20);
        check("simul_c_cycle", last_c - start, 6);
        check("simul_q_cycle", last_q - start, 7);
        check("simul_counts", (n_c - b_c) * 10 + (n_q - b_q), 11);
        check("simul_never_both", n_both, 0);
        c_raw = 1'b0; q_raw = 1'b0; tick(12);

        // Keys 00101, pressed twice
        b_k0 = n_k0; b_k2 = n_k2; b_ko = n_kother; start = cyc + 1; key_raw = 5'b00101;
        tick(20);
        check("key_cycle", last_k - start, 6);
        check("key_value", int'(last_kval), 5);
        check("key_first_count", n_k0 - b_k0, 1);
        key_raw = 5'd0; tick(20);
        key_raw = 5'b00101; tick(20);
        key_raw = 5'd0; tick(12);
        check("key_bit0_count", n_k0 - b_k0, 2);
        check("key_bit2_count", n_k2 - b_k2, 2);
        check("key_other_count", n_kother - b_ko, 0);

        // Reset while a press is being debounced
        b_c = n_c; start = cyc + 1; c_raw = 1'b1;
        tick(4);
        rst = 1'b0; tick(1);
        check("midreset_outputs", int'({c_pulse, q_pulse, key_pulse, coin_reject}), 0);
        check("midreset_no_c", n_c - b_c, 0);
        rst = 1'b1; tick(15);
        check("postreset_c_count", n_c - b_c, 1);
        check("postreset_c_cycle", last_c - start, 11);
        c_raw = 1'b0; tick(12);

        // Controller not accepting coins
        b_q = n_q; b_r = n_r_snapshot();
        accept_coin = 1'b0; q_raw = 1'b1; tick(12); q_raw = 1'b0; tick(12);
        check("refused_q_count", n_q - b_q, REJ_EN ? 0 : 1);
        check("refused_reject_count", n_rej - b_r, REJ_EN ? 1 : 0);
        b_q = n_q; b_r = n_rej;
        accept_coin = 1'b1; q_raw = 1'b1; tick(12); q_raw = 1'b0; tick(12);
        check("accepted_q_count", n_q - b_q, 1);
        check("accepted_reject_count", n_rej - b_r, 0);

        // Mixed traffic on all channels, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            {key_raw, q_raw, c_raw} = 7'($urandom);
            accept_coin = 1'($urandom);
            tick($urandom_range(1, 10));
        end
        {key_raw, q_raw, c_raw} = 7'd0; accept_coin = 1'b1;
        tick(20);
        check("random_never_both", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int n_r_snapshot();
        return n_rej;
    endfunction

endmodule
